icache: RTL and testbench

ICACHE -- requirements
Module: icache

---
 rtl/icache_pkg.sv | 21 ++
 rtl/icache_array.sv | 47 ++++
 rtl/icache.sv | 132 +++++++++++++
 tb/tb_icache.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/icache_pkg.sv
// Shared constants, geometry and FSM state type for the direct-mapped
// instruction cache.
package icache_pkg;

  localparam logic [12:0] TAG_READ_MEM = 13'h0101;
  localparam int LINE_BYTES = 64;
  localparam int NUM_LINES  = 16;
  localparam int OFFSET_W   = $clog2(LINE_BYTES);
  localparam int INDEX_W    = $clog2(NUM_LINES);
  localparam int TAG_W      = 64 - OFFSET_W - INDEX_W;
  localparam int LINE_W     = LINE_BYTES * 8;

  typedef enum logic [2:0] {
    IDLE,
    LOOKUP,
    REQ,
    FILL,
    RESPOND
  } ic_state_e;

endpackage

// File: rtl/icache_array.sv
// Tag/valid/data storage: 16 lines, combinational read port, one write port,
// and a flash clear of every valid bit.
module icache_array
  import icache_pkg::*;
(
  input  logic               clk,
  input  logic               reset_n,
  input  logic [INDEX_W-1:0] rd_idx,
  output logic               rd_valid,
  output logic [TAG_W-1:0]   rd_tag,
  output logic [LINE_W-1:0]  rd_data,
  input  logic               wr_en,
  input  logic [INDEX_W-1:0] wr_idx,
  input  logic [TAG_W-1:0]   wr_tag,
  input  logic [LINE_W-1:0]  wr_data,
  input  logic               wr_valid,
  input  logic               clear
);

  logic [NUM_LINES-1:0] valid_q, valid_d;
  logic [TAG_W-1:0]     tag_q  [NUM_LINES];
  logic [LINE_W-1:0]    data_q [NUM_LINES];

  // A clear on the same edge as a write leaves the written line invalid.
  always_comb begin
    valid_d = valid_q;
    if (wr_en) valid_d[wr_idx] = wr_valid;
    if (clear) valid_d = '0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) valid_q <= '0;
    else          valid_q <= valid_d;
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      tag_q[wr_idx]  <= wr_tag;
      data_q[wr_idx] <= wr_data;
    end
  end

  assign rd_valid = valid_q[rd_idx];
  assign rd_tag   = tag_q[rd_idx];
  assign rd_data  = data_q[rd_idx];

endmodule

// File: rtl/icache.sv
// Direct-mapped instruction cache: 16 x 64-byte lines, misses filled by
// eight 64-bit response beats from the memory bus.
module icache
  import icache_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic              ic_enable,
  input  logic [63:0]       iaddr,
  output logic [LINE_W-1:0] idata,
  output logic              ic_done,
  input  logic              invalidate,
  output logic              bus_reqcyc,
  output logic [63:0]       bus_req,
  output logic [12:0]       bus_reqtag,
  input  logic              bus_reqack,
  input  logic              bus_respcyc,
  input  logic [63:0]       bus_resp,
  output logic              bus_respack
);

  ic_state_e         state_q, state_d;
  logic [63:0]       addr_q, addr_d;
  logic [2:0]        cnt_q, cnt_d;
  logic [LINE_W-1:0] line_q, line_d;
  logic [LINE_W-1:0] idata_q, idata_d;
  logic              inv_seen_q, inv_seen_d;

  logic              rd_valid;
  logic [TAG_W-1:0]  rd_tag;
  logic [LINE_W-1:0] rd_data;
  logic              wr_en;
  logic              hit;
  logic [LINE_W-1:0] fill_line;

  icache_array u_array (
    .clk      (clk),
    .reset_n  (reset_n),
    .rd_idx   (addr_q[OFFSET_W +: INDEX_W]),
    .rd_valid (rd_valid),
    .rd_tag   (rd_tag),
    .rd_data  (rd_data),
    .wr_en    (wr_en),
    .wr_idx   (addr_q[OFFSET_W +: INDEX_W]),
    .wr_tag   (addr_q[63 -: TAG_W]),
    .wr_data  (fill_line),
    .wr_valid (!(inv_seen_q || invalidate)),
    .clear    (invalidate)
  );

  assign hit = rd_valid && (rd_tag == addr_q[63 -: TAG_W]);

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    cnt_d      = cnt_q;
    line_d     = line_q;
    idata_d    = idata_q;
    inv_seen_d = inv_seen_q;
    wr_en      = 1'b0;
    fill_line  = line_q;
    fill_line[{cnt_q, 6'b0} +: 64] = bus_resp;

    case (state_q)
      IDLE: begin
        if (ic_enable) begin
          addr_d  = iaddr & ~64'(LINE_BYTES - 1);
          state_d = LOOKUP;
        end
      end
      LOOKUP: begin
        if (hit) begin
          idata_d = rd_data;
          state_d = RESPOND;
        end else begin
          state_d = REQ;
        end
      end
      REQ: begin
        if (bus_reqack) begin
          cnt_d      = '0;
          inv_seen_d = 1'b0;
          state_d    = FILL;
        end
      end
      FILL: begin
        // An invalidate seen mid-fill keeps the incoming line from becoming valid.
        if (invalidate) inv_seen_d = 1'b1;
        if (bus_respcyc) begin
          line_d = fill_line;
          cnt_d  = cnt_q + 3'd1;
          if (cnt_q == 3'd7) begin
            wr_en   = 1'b1;
            idata_d = fill_line;
            state_d = RESPOND;
          end
        end
      end
      RESPOND: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      cnt_q      <= '0;
      idata_q    <= '0;
      inv_seen_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      cnt_q      <= cnt_d;
      idata_q    <= idata_d;
      inv_seen_q <= inv_seen_d;
    end
  end

  // Fill buffer lanes are all overwritten before use, so no reset.
  always_ff @(posedge clk) begin
    line_q <= line_d;
  end

  assign idata       = idata_q;
  assign ic_done     = (state_q == RESPOND);
  assign bus_reqcyc  = (state_q == REQ);
  assign bus_req     = bus_reqcyc ? addr_q : '0;
  assign bus_reqtag  = TAG_READ_MEM;
  assign bus_respack = bus_respcyc;

endmodule

// File: tb/tb_icache.sv
// Directed plus randomized bench for icache against a line-level cache model.
module tb_icache;
  import icache_pkg::*;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         ic_enable = 1'b0;
  logic [63:0]  iaddr = '0;
  logic [511:0] idata;
  logic         ic_done;
  logic         invalidate = 1'b0;
  logic         bus_reqcyc;
  logic [63:0]  bus_req;
  logic [12:0]  bus_reqtag;
  logic         bus_reqack = 1'b0;
  logic         bus_respcyc = 1'b0;
  logic [63:0]  bus_resp = '0;
  logic         bus_respack;

  int checks = 0;
  int errors = 0;

  bit           m_valid [16];
  logic [53:0]  m_tag   [16];
  logic [511:0] m_data  [16];
  logic [511:0] m_last;

  always #5 clk = ~clk;

  icache dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .ic_enable   (ic_enable),
    .iaddr       (iaddr),
    .idata       (idata),
    .ic_done     (ic_done),
    .invalidate  (invalidate),
    .bus_reqcyc  (bus_reqcyc),
    .bus_req     (bus_req),
    .bus_reqtag  (bus_reqtag),
    .bus_reqack  (bus_reqack),
    .bus_respcyc (bus_respcyc),
    .bus_resp    (bus_resp),
    .bus_respack (bus_respack)
  );

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_clear();
    foreach (m_valid[i]) m_valid[i] = 1'b0;
  endtask

  // Idle cycles with response-bus noise; inv_mode 0 none, 1 forced, 2 random.
  task automatic idle(input int n, input int inv_mode);
    for (int c = 0; c < n; c++) begin
      bus_respcyc = 1'($urandom_range(0, 1));
      bus_resp    = {$urandom, $urandom};
      invalidate  = (inv_mode == 1 && c == 0) || (inv_mode == 2 && $urandom_range(0, 9) == 0);
      #1;
      chk("idle_respack", bus_respack, bus_respcyc);
      chk("idle_done", ic_done, 0);
      chk("idle_reqcyc", bus_reqcyc, 0);
      chk("idle_idata", idata, m_last);
      if (invalidate) model_clear();
      step();
      bus_respcyc = 1'b0;
      invalidate  = 1'b0;
    end
  endtask

  task automatic fetch(input logic [63:0] a, input int ack_dly, input int inv_beat,
                       input bit inv_lookup, input int rst_beat, input logic [63:0] base);
    logic [3:0]   idx;
    logic [53:0]  tg;
    bit           hit;
    logic [511:0] line;
    logic [63:0]  beat;
    logic [63:0]  beat0;
    idx  = a[9:6];
    tg   = a[63:10];
    hit  = m_valid[idx] && (m_tag[idx] == tg);
    line = '0;
    beat0 = '0;

    ic_enable = 1'b1;
    iaddr     = a;
    step();
    ic_enable = 1'b0;
    iaddr     = {$urandom, $urandom};
    chk("lookup_done", ic_done, 0);
    chk("lookup_reqcyc", bus_reqcyc, 0);

    if (hit) begin
      invalidate = inv_lookup;
      step();
      invalidate = 1'b0;
      chk("hit_done", ic_done, 1);
      chk("hit_data", idata, m_data[idx]);
      chk("hit_noreq", bus_reqcyc, 0);
      m_last = m_data[idx];
      if (inv_lookup) model_clear();
      step();
      chk("hit_pulse", ic_done, 0);
      return;
    end

    step();
    for (int c = 0; c <= ack_dly; c++) begin
      chk("req_cyc", bus_reqcyc, 1);
      chk("req_addr", bus_req, a & ~64'h3f);
      chk("req_tag", bus_reqtag, TAG_READ_MEM);
      chk("req_nodone", ic_done, 0);
      bus_reqack = (c == ack_dly);
      step();
      bus_reqack = 1'b0;
    end

    for (int k = 0; k < 8; k++) begin
      int g;
      g = $urandom_range(0, 2);
      for (int j = 0; j < g; j++) begin
        chk("fill_nodone", ic_done, 0);
        chk("fill_noreq", bus_reqcyc, 0);
        ic_enable = 1'($urandom_range(0, 1));
        iaddr     = {$urandom, $urandom};
        step();
        ic_enable = 1'b0;
      end
      beat = (base != 0) ? base + 64'(k) : {$urandom, $urandom};
      if (k == 0) beat0 = beat;
      line[64*k +: 64] = beat;
      bus_respcyc = 1'b1;
      bus_resp    = beat;
      invalidate  = (k == inv_beat);
      if (k == rst_beat) begin
        reset_n     = 1'b0;
        bus_respcyc = 1'b0;
        invalidate  = 1'b0;
        #1;
        chk("rst_done", ic_done, 0);
        chk("rst_reqcyc", bus_reqcyc, 0);
        chk("rst_req", bus_req, 0);
        chk("rst_idata", idata, 0);
        chk("rst_respack", bus_respack, 0);
        step();
        reset_n = 1'b1;
        model_clear();
        m_last = '0;
        for (int j = k; j < 10; j++) begin
          bus_respcyc = (j < 8);
          bus_resp    = {$urandom, $urandom};
          step();
          chk("late_nodone", ic_done, 0);
          chk("late_noreq", bus_reqcyc, 0);
        end
        bus_respcyc = 1'b0;
        return;
      end
      #1;
      chk("fill_respack", bus_respack, 1);
      step();
      bus_respcyc = 1'b0;
      invalidate  = 1'b0;
    end

    chk("miss_done", ic_done, 1);
    chk("miss_data", idata, line);
    chk("miss_lane0", idata[63:0], beat0);
    chk("miss_lane7", idata[511:448], beat);
    m_last = line;
    if (inv_beat >= 0) begin
      model_clear();
    end else begin
      m_valid[idx] = 1'b1;
      m_tag[idx]   = tg;
      m_data[idx]  = line;
    end
    step();
    chk("miss_pulse", ic_done, 0);
    chk("miss_hold", idata, line);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    model_clear();
    m_last = '0;
    #1;
    chk("reset_done", ic_done, 0);
    chk("reset_reqcyc", bus_reqcyc, 0);
    chk("reset_req", bus_req, 0);
    chk("reset_idata", idata, 0);
    step();
    step();
    reset_n = 1'b1;
    step();

    fetch(64'h1000, 0, -1, 1'b0, -1, 64'h0123_4567_89ab_cd00);
    idle(2, 0);
    fetch(64'h1020, 0, -1, 1'b0, -1, 64'h0);
    fetch(64'h1400, 1, -1, 1'b0, -1, 64'h0);
    fetch(64'h1000, 5, -1, 1'b0, -1, 64'h0);
    idle(1, 1);
    fetch(64'h1000, 0, 3, 1'b0, -1, 64'h0);
    fetch(64'h1000, 2, -1, 1'b0, -1, 64'h0);
    fetch(64'h1000, 0, -1, 1'b1, -1, 64'h0);
    fetch(64'h1000, 0, -1, 1'b0, -1, 64'h0);
    idle(1, 1);
    fetch(64'h1000, 0, -1, 1'b0, 4, 64'h0);
    chk("post_rst_idata", idata, 0);
    fetch(64'h1000, 0, -1, 1'b0, -1, 64'h0);

    for (int n = 0; n < 60; n++) begin
      logic [53:0] tg;
      logic [3:0]  ix;
      logic [5:0]  off;
      tg  = 54'($urandom_range(0, 2));
      ix  = 4'($urandom_range(0, 3));
      off = 6'($urandom_range(0, 63));
      fetch({tg, ix, off}, $urandom_range(0, 3),
            ($urandom_range(0, 5) == 0) ? $urandom_range(0, 7) : -1,
            1'($urandom_range(0, 7) == 0), -1, 64'h0);
      idle($urandom_range(0, 2), 2);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
